sprite_anim_sequencer: RTL and testbench
========================================

// Module: sprite_anim_sequencer
// PURPOSE
//  Sequences a multi-frame sprite strip held in one sprite ROM (frames stored back to back).
//  Steps the frame index on vertical-frame ticks, with a programmable hold count and
//  one-shot or loop playback.
//  Each cycle, turns the raster position (DrawX/DrawY) plus the sprite screen position
//  into a registered ROM address and a pixel-valid flag.
//  Sits between the VGA controller and the sprite ROM/palette pair.
// PARAMETERS
//  NUM_FRAMES  4    frames in the strip (>=2)
//  FRAME_W     70   frame width in pixels
//  FRAME_H     120  frame height in pixels
//  ADDR_W      16   ROM address width; must satisfy NUM_FRAMES*FRAME_W*FRAME_H <= 2**ADDR_W
// PORTS
//  vga_clk      in   1       pixel clock; the only clock
//  Reset        in   1       synchronous, active-high reset
//  frame_start  in   1       one-cycle pulse once per video frame (start of vsync)
//  start        in   1       one-cycle trigger: play from frame 0
//  stop         in   1       one-cycle abort to IDLE
//  loop_en      in   1       1 = loop continuously; 0 = one-shot
//  hold_ticks   in   8       extra frame_start pulses to hold each frame (0 = advance on every pulse)
//  DrawX,DrawY  in   10      current raster pixel
//  pos_x,pos_y  in   10      sprite top-left corner on screen
//  blank        in   1       1 = active video
//  rom_address  out  ADDR_W  registered ROM address
//  pixel_valid  out  1       registered; rom_address points at a live sprite pixel
//  frame_idx    out  $clog2(NUM_FRAMES)  current frame
//  busy         out  1       1 while in PLAY
//  done         out  1       one-cycle pulse when a one-shot run completes
// BEHAVIOUR
//  Reset: state=IDLE; frame_idx=0, base=0, tick_cnt=0; all outputs 0.
//  States:
//   IDLE - start -> PLAY: frame_idx=0, base=0, tick_cnt=0.
//   PLAY - on frame_start:
//     tick_cnt<hold_ticks -> tick_cnt++.
//     tick_cnt==hold_ticks -> tick_cnt=0 and the frame advances.
//  Advance:
//   frame_idx<NUM_FRAMES-1 -> frame_idx++, base+=FRAME_W*FRAME_H. Base is updated
//   incrementally; there is no multiplier on frame_idx.
//   At the last frame, loop_en is sampled in that cycle:
//     loop_en=1 -> frame_idx=0, base=0.
//     loop_en=0 -> IDLE, frame_idx=0, base=0, done=1 for exactly one cycle.
//  Frame and base change only on frame_start, so no mid-frame tearing.
//  Priority:
//   stop > start > frame_start.
//   stop: IDLE next cycle, no done pulse.
//   start while in PLAY restarts at frame 0 and clears tick_cnt.
//   frame_start in the same cycle as an accepted start is ignored.
//   hold_ticks is sampled live; if lowered below tick_cnt, advance on the next frame_start.
//  Pixel path (1-cycle latency):
//   in_box = DrawX>=pos_x && DrawX<pos_x+FRAME_W && DrawY>=pos_y && DrawY<pos_y+FRAME_H.
//   Sums are 11-bit, so there is no wrap at the right/bottom screen edge.
//   pixel_valid <= in_box & blank & busy.
//   rom_address <= in_box ? base + (DrawY-pos_y)*FRAME_W + (DrawX-pos_x) : base.
//   The multiply is by a constant only.
//   In IDLE, rom_address <= 0 and pixel_valid <= 0.
// CONFIGURATION
//  ANIM_PINGPONG_EN defined:
//   At the last frame, direction reverses and frames step down (base-=FRAME_W*FRAME_H).
//   At frame 0 while descending: loop_en=1 -> ascend again; loop_en=0 -> finish
//   (IDLE plus the done pulse).
//   start resets the direction to ascending.
//  ANIM_PINGPONG_EN undefined: forward-only wrap/finish as described above; no direction
//  register.
// TESTING
//  1. Reset held 3 cycles -> all outputs 0, busy=0. Then start with hold_ticks=0,
//     loop_en=0, 4 frame_start pulses -> frame_idx 0,1,2,3.
//     On the 4th pulse: done=1 for one cycle, busy=0, frame_idx=0.
//  2. hold_ticks=2, loop_en=1 -> frame_idx advances every 3rd frame_start;
//     sequence 0,1,2,3,0,1 and done is never asserted.
//  3. busy, frame_idx=2, pos=(100,50), DrawX=100, DrawY=50, blank=1
//     -> next cycle rom_address=16800, pixel_valid=1.
//     DrawX=169, DrawY=169 -> rom_address=16800+119*70+69=25199.
//     DrawX=170 -> pixel_valid=0.
//  4. stop and start in the same cycle during PLAY -> IDLE, no done pulse.
//     start together with frame_start in IDLE -> frame_idx=0 and tick_cnt=0 on the
//     next cycle.
//  5. Reset asserted mid-PLAY at frame_idx=3 -> next cycle state IDLE and all outputs 0.
//     pos_x=600, DrawX=639 -> in_box=1 with no overflow.
//  6. ANIM_PINGPONG_EN, hold_ticks=0, loop_en=1 -> frame_idx 0,1,2,3,2,1,0,1.
//     With loop_en=0 -> 0,1,2,3,2,1,0, then done.

Source files
------------

// File: rtl/sprite_anim_sequencer.sv
// Frame sequencer and raster-to-ROM address generator for a multi-frame sprite strip.
// Optional ANIM_PINGPONG_EN macro: ping-pong playback instead of forward wrap.
module sprite_anim_sequencer #(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_W    = 70,
  parameter int FRAME_H    = 120,
  parameter int ADDR_W     = 16
) (
  input  logic                          vga_clk,
  input  logic                          Reset,
  input  logic                          frame_start,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  input  logic [7:0]                    hold_ticks,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          blank,
  output logic [ADDR_W-1:0]             rom_address,
  output logic                          pixel_valid,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int                FIDX_W   = $clog2(NUM_FRAMES);
  localparam logic [FIDX_W-1:0] LAST_FR  = FIDX_W'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(FRAME_W * FRAME_H);
  localparam logic [10:0]       FW11     = 11'(FRAME_W);
  localparam logic [10:0]       FH11     = 11'(FRAME_H);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [FIDX_W-1:0]   frame_q, frame_d;
  logic [ADDR_W-1:0]   base_q,  base_d;
  logic [7:0]          tick_q,  tick_d;
  logic                done_q,  done_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic                pv_q,    pv_d;
`ifdef ANIM_PINGPONG_EN
  logic                desc_q,  desc_d;
`endif

  logic [10:0]         x11, y11, px11, py11, rel_x, rel_y;
  logic                in_box;
  logic [ADDR_W-1:0]   pix_off;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      base_q  <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      pv_q    <= 1'b0;
`ifdef ANIM_PINGPONG_EN
      desc_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      base_q  <= base_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      pv_q    <= pv_d;
`ifdef ANIM_PINGPONG_EN
      desc_q  <= desc_d;
`endif
    end
  end

  // Sequencing: stop beats start, start beats frame_start; frames only move on frame_start.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    base_d  = base_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
`ifdef ANIM_PINGPONG_EN
    desc_d  = desc_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      frame_d = '0;
      base_d  = '0;
      tick_d  = '0;
`ifdef ANIM_PINGPONG_EN
      desc_d  = 1'b0;
`endif
    end else if (start) begin
      state_d = S_PLAY;
      frame_d = '0;
      base_d  = '0;
      tick_d  = '0;
`ifdef ANIM_PINGPONG_EN
      desc_d  = 1'b0;
`endif
    end else if (state_q == S_PLAY && frame_start) begin
      if (tick_q < hold_ticks) begin
        tick_d = tick_q + 8'd1;
      end else begin
        tick_d = '0;
`ifdef ANIM_PINGPONG_EN
        if (!desc_q) begin
          if (frame_q != LAST_FR) begin
            frame_d = frame_q + FIDX_W'(1);
            base_d  = base_q + FRAME_SZ;
          end else begin
            desc_d  = 1'b1;
            frame_d = frame_q - FIDX_W'(1);
            base_d  = base_q - FRAME_SZ;
          end
        end else begin
          if (frame_q != '0) begin
            frame_d = frame_q - FIDX_W'(1);
            base_d  = base_q - FRAME_SZ;
          end else if (loop_en) begin
            desc_d  = 1'b0;
            frame_d = FIDX_W'(1);
            base_d  = FRAME_SZ;
          end else begin
            desc_d  = 1'b0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
`else
        if (frame_q != LAST_FR) begin
          frame_d = frame_q + FIDX_W'(1);
          base_d  = base_q + FRAME_SZ;
        end else begin
          frame_d = '0;
          base_d  = '0;
          if (!loop_en) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
`endif
      end
    end
  end

  // 11-bit compares keep the box from wrapping at the right/bottom screen edge.
  always_comb begin
    x11     = {1'b0, DrawX};
    y11     = {1'b0, DrawY};
    px11    = {1'b0, pos_x};
    py11    = {1'b0, pos_y};
    rel_x   = x11 - px11;
    rel_y   = y11 - py11;
    in_box  = (x11 >= px11) && (x11 < px11 + FW11) &&
              (y11 >= py11) && (y11 < py11 + FH11);
    pix_off = ADDR_W'(rel_y) * ADDR_W'(FRAME_W) + ADDR_W'(rel_x);
    pv_d    = in_box && blank && (state_q == S_PLAY);
    if (state_q == S_IDLE) begin
      addr_d = '0;
    end else if (in_box) begin
      addr_d = base_q + pix_off;
    end else begin
      addr_d = base_q;
    end
  end

  assign rom_address = addr_q;
  assign pixel_valid = pv_q;
  assign frame_idx   = frame_q;
  assign busy        = (state_q == S_PLAY);
  assign done        = done_q;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Bench for sprite_anim_sequencer: directed literal checks plus randomized run against a playback model.
module tb_sprite_anim_sequencer;
  localparam int NF = 4;
  localparam int FW = 70;
  localparam int FH = 120;
  localparam int AW = 16;

  logic          vga_clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_start = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0, blank = 1'b0;
  logic [7:0]    hold_ticks = 8'd0;
  logic [9:0]    DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic [AW-1:0] rom_address;
  logic          pixel_valid, busy, done;
  logic [1:0]    frame_idx;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: playback as a list position, not as an FSM encoding.
  bit m_play, m_desc;
  int m_frame, m_tick;
  int e_addr, e_frame;
  bit e_pv, e_busy, e_done;

  sprite_anim_sequencer #(.NUM_FRAMES(NF), .FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW)) dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start), .start(start), .stop(stop),
    .loop_en(loop_en), .hold_ticks(hold_ticks), .DrawX(DrawX), .DrawY(DrawY),
    .pos_x(pos_x), .pos_y(pos_y), .blank(blank), .rom_address(rom_address),
    .pixel_valid(pixel_valid), .frame_idx(frame_idx), .busy(busy), .done(done)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish();
    m_play = 0; m_frame = 0; m_tick = 0; m_desc = 0;
  endtask

  task automatic model_advance();
`ifdef ANIM_PINGPONG_EN
    if (!m_desc) begin
      if (m_frame < NF-1) m_frame++;
      else begin m_desc = 1; m_frame--; end
    end else if (m_frame > 0) m_frame--;
    else if (loop_en) begin m_desc = 0; m_frame = 1; end
    else begin model_finish(); e_done = 1; end
`else
    if (m_frame < NF-1) m_frame++;
    else if (loop_en) m_frame = 0;
    else begin model_finish(); e_done = 1; end
`endif
  endtask

  task automatic model_step();
    int rx, ry;
    bit inb;
    rx  = int'(DrawX) - int'(pos_x);
    ry  = int'(DrawY) - int'(pos_y);
    inb = rx >= 0 && rx < FW && ry >= 0 && ry < FH;
    e_done = 0;
    if (Reset) begin
      model_finish();
      e_pv = 0; e_addr = 0;
    end else begin
      e_pv   = inb && blank && m_play;
      e_addr = !m_play ? 0 : (m_frame * FW * FH + (inb ? ry * FW + rx : 0));
      if (stop) model_finish();
      else if (start) begin m_play = 1; m_frame = 0; m_tick = 0; m_desc = 0; end
      else if (m_play && frame_start) begin
        if (m_tick < int'(hold_ticks)) m_tick++;
        else begin m_tick = 0; model_advance(); end
      end
    end
    e_busy = m_play; e_frame = m_frame;
  endtask

  always @(negedge vga_clk) begin
    if (chk_en) begin
      chk("rom_address", 32'(rom_address), 32'(e_addr));
      chk("pixel_valid", 32'(pixel_valid), 32'(e_pv));
      chk("frame_idx", 32'(frame_idx), 32'(e_frame));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
    end
  end

  task automatic cyc();
    @(posedge vga_clk);
    model_step();
    @(negedge vga_clk);
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic pulse_fs();
    frame_start = 1; cyc(); frame_start = 0;
  endtask

  initial begin
    int seq1 [7];
    int seq2 [5];
`ifdef ANIM_PINGPONG_EN
    seq1 = '{1, 2, 3, 2, 1, 0, 1};
    seq2 = '{1, 2, 3, 2, 1};
`else
    seq1 = '{1, 2, 3, 0, 0, 0, 0};
    seq2 = '{1, 2, 3, 0, 1};
`endif
    chk_en = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_addr", 32'(rom_address), 32'd0);
    end
    Reset = 0;

    // One-shot playback
    hold_ticks = 0; loop_en = 0;
    pulse_start();
    chk("t1_start_frame", 32'(frame_idx), 32'd0);
    chk("t1_start_busy", 32'(busy), 32'd1);
`ifdef ANIM_PINGPONG_EN
    for (int p = 0; p < 6; p++) begin
      pulse_fs(); chk("t6_oneshot_seq", 32'(frame_idx), 32'(seq1[p])); cyc();
    end
    pulse_fs();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    cyc();
    loop_en = 1;
    pulse_start();
    for (int p = 0; p < 7; p++) begin
      pulse_fs(); chk("t6_loop_seq", 32'(frame_idx), 32'(seq1[p])); cyc();
    end
`else
    for (int p = 0; p < 4; p++) begin
      pulse_fs(); chk("t1_seq", 32'(frame_idx), 32'(seq1[p]));
      if (p < 3) cyc();
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
`endif
    cyc();
    chk("t1_done_drop", 32'(done), 32'd0);

    // Hold count with looping
    hold_ticks = 2; loop_en = 1;
    pulse_start();
    for (int p = 1; p <= 15; p++) begin
      pulse_fs();
      if (p % 3 == 0) chk("t2_hold_seq", 32'(frame_idx), 32'(seq2[p/3 - 1]));
      cyc();
    end

    // Pixel addressing at frame 2
    hold_ticks = 0;
    pulse_start(); pulse_fs(); pulse_fs();
    chk("t3_frame", 32'(frame_idx), 32'd2);
    pos_x = 100; pos_y = 50; DrawX = 100; DrawY = 50; blank = 1;
    cyc();
    chk("t3_addr_tl", 32'(rom_address), 32'd16800);
    chk("t3_pv_tl", 32'(pixel_valid), 32'd1);
    DrawX = 169; DrawY = 169;
    cyc();
    chk("t3_addr_br", 32'(rom_address), 32'd25199);
    DrawX = 170;
    cyc();
    chk("t3_pv_out", 32'(pixel_valid), 32'd0);

    // Priority
    stop = 1; start = 1; cyc(); stop = 0; start = 0;
    chk("t4_stop_busy", 32'(busy), 32'd0);
    chk("t4_stop_done", 32'(done), 32'd0);
    hold_ticks = 1;
    start = 1; frame_start = 1; cyc(); start = 0; frame_start = 0;
    chk("t4_sf_frame", 32'(frame_idx), 32'd0);
    pulse_fs(); chk("t4_tick_hold", 32'(frame_idx), 32'd0);
    pulse_fs(); chk("t4_tick_adv", 32'(frame_idx), 32'd1);

    // Reset mid-play, then right-edge box
    hold_ticks = 0; loop_en = 1;
    pulse_start(); pulse_fs(); pulse_fs(); pulse_fs();
    chk("t5_frame3", 32'(frame_idx), 32'd3);
    DrawX = 105; DrawY = 55;
    Reset = 1; cyc(); Reset = 0;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_frame", 32'(frame_idx), 32'd0);
    chk("t5_rst_addr", 32'(rom_address), 32'd0);
    chk("t5_rst_pv", 32'(pixel_valid), 32'd0);
    pulse_start();
    pos_x = 600; pos_y = 10; DrawX = 639; DrawY = 10;
    cyc();
    chk("t5_edge_pv", 32'(pixel_valid), 32'd1);
    chk("t5_edge_addr", 32'(rom_address), 32'd39);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      frame_start = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 60) == 0);
      stop = ($urandom_range(0, 150) == 0);
      Reset = ($urandom_range(0, 700) == 0);
      if ($urandom_range(0, 40) == 0) loop_en = $urandom_range(0, 1);
      if ($urandom_range(0, 30) == 0) hold_ticks = 8'($urandom_range(0, 3));
      pos_x = 10'($urandom_range(5, 600));
      pos_y = 10'($urandom_range(5, 400));
      DrawX = pos_x + 10'($urandom_range(0, 78)) - 10'd3;
      DrawY = pos_y + 10'($urandom_range(0, 128)) - 10'd3;
      blank = ($urandom_range(0, 7) != 0);
      cyc();
    end
    Reset = 0; start = 0; stop = 0; frame_start = 0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
